// File: rtl/gecko_muldiv_sequencer.sv
// gecko_muldiv_sequencer
// Iterative RV32M multiply/divide unit. One operation at a time: operands are
// captured as magnitudes plus signs, 32 shift-add (MULT) or restoring-divide
// (DIV) steps run on a shared hi/lo register pair, a single fix-up cycle applies
// signs and selects the result, and the result is held until writeback takes it.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   op_valid/op_ready         operation handshake from execute
//   op_is_div, op_math_type   operation select (MULT: MUL/MULH/MULHU/MULHSU,
//                             DIV: DIV/DIVU/REM/REMU)
//   op_a, op_b                rs1 / rs2 values
//   op_reg_addr/_status,
//   op_jump_flag              destination metadata, echoed with the result
//   flush                     kill any in-flight or pending result
//   busy                      not idle
//   result_valid/result_ready writeback handshake
//   result_value/_addr/
//   _reg_status/_jump_flag    result and captured metadata
module gecko_muldiv_sequencer #(
    parameter int ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_is_div,
    input  logic [1:0]  op_math_type,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  op_reg_addr,
    input  logic [2:0]  op_reg_status,
    input  logic        op_jump_flag,
    input  logic        flush,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result_value,
    output logic [4:0]  result_addr,
    output logic [2:0]  result_reg_status,
    output logic        result_jump_flag
);
    localparam int CW = $clog2(ITERATIONS);
    localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, ITERATE, FIXUP, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic          is_div_q, sa_q, sb_q, dz_q;
    logic [1:0]    type_q;
    logic [31:0]   opnd_q;   // multiplicand or divisor magnitude
    logic [31:0]   hi_q;     // product high half / partial remainder
    logic [31:0]   lo_q;     // product low half / dividend-quotient
    logic [4:0]    meta_addr_q;
    logic [2:0]    meta_status_q;
    logic          meta_jump_q;
    logic [31:0]   res_value_q;
    logic [4:0]    res_addr_q;
    logic [2:0]    res_status_q;
    logic          res_jump_q;

    logic        accept, a_signed, b_signed, sa_d, sb_d, dz_d;
    logic [31:0] mag_a_d, mag_b_d, hi_d, lo_d, diff, quo, rem, fix_d;
    logic [32:0] mul_sum, div_shift;
    logic        div_ok;
    logic [63:0] prod, prod_s;

    assign op_ready     = ~flush & ((state_q == IDLE) | ((state_q == DONE) & result_ready));
    assign accept       = op_valid & op_ready;
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);

    assign result_value      = res_value_q;
    assign result_addr       = res_addr_q;
    assign result_reg_status = res_status_q;
    assign result_jump_flag  = res_jump_q;

    // Operand signedness: a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
    always_comb begin
        a_signed = op_is_div ^ op_math_type[0];
        b_signed = op_is_div ? ~op_math_type[0] : (op_math_type == 2'd1);
        sa_d     = a_signed & op_a[31];
        sb_d     = b_signed & op_b[31];
        mag_a_d  = sa_d ? -op_a : op_a;
        mag_b_d  = sb_d ? -op_b : op_b;
        dz_d     = op_is_div & (op_b == 32'd0);
    end

    // One iteration step.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {hi_q, lo_q[31]};
        div_ok    = (div_shift >= {1'b0, opnd_q});
        // On a successful trial the difference is below the divisor, so the
        // low 32 bits of the subtraction are exact.
        diff      = div_shift[31:0] - opnd_q;
        if (is_div_q) begin
            hi_d = div_ok ? diff : div_shift[31:0];
            lo_d = {lo_q[30:0], div_ok};
        end else begin
            hi_d = mul_sum[32:1];
            lo_d = {mul_sum[0], lo_q[31:1]};
        end
    end

    // Sign fix-up and result select. For divide by zero hi_q holds |a|, so the
    // remainder path reproduces op_a without a separate copy.
    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = (sa_q ^ sb_q) ? -prod : prod;
        quo    = (sa_q ^ sb_q) ? -lo_q : lo_q;
        rem    = sa_q ? -hi_q : hi_q;
        if (is_div_q) begin
            if (type_q[1]) fix_d = rem;
            else           fix_d = dz_q ? 32'hFFFF_FFFF : quo;
        end else begin
            fix_d = (type_q == 2'd0) ? prod_s[31:0] : prod_s[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            is_div_q      <= 1'b0;
            type_q        <= 2'd0;
            sa_q          <= 1'b0;
            sb_q          <= 1'b0;
            dz_q          <= 1'b0;
            opnd_q        <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            meta_addr_q   <= '0;
            meta_status_q <= '0;
            meta_jump_q   <= 1'b0;
            res_value_q   <= '0;
            res_addr_q    <= '0;
            res_status_q  <= '0;
            res_jump_q    <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            count_q <= '0;
        end else if (accept) begin
            // accept only fires in IDLE, or in DONE while the result is taken
            state_q       <= dz_d ? FIXUP : ITERATE;
            count_q       <= '0;
            is_div_q      <= op_is_div;
            type_q        <= op_math_type;
            sa_q          <= sa_d;
            sb_q          <= sb_d;
            dz_q          <= dz_d;
            opnd_q        <= mag_b_d;
            hi_q          <= dz_d ? mag_a_d : 32'd0;
            lo_q          <= mag_a_d;
            meta_addr_q   <= op_reg_addr;
            meta_status_q <= op_reg_status;
            meta_jump_q   <= op_jump_flag;
        end else begin
            case (state_q)
                ITERATE: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) state_q <= FIXUP;
                end
                FIXUP: begin
                    res_value_q  <= fix_d;
                    res_addr_q   <= meta_addr_q;
                    res_status_q <= meta_status_q;
                    res_jump_q   <= meta_jump_q;
                    state_q      <= DONE;
                end
                DONE: if (result_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gecko_muldiv_sequencer.sv
module tb_gecko_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0, op_is_div = 1'b0, op_jump_flag = 1'b0;
    logic [1:0]  op_math_type = 2'd0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [4:0]  op_reg_addr = '0;
    logic [2:0]  op_reg_status = '0;
    logic        flush = 1'b0, result_ready = 1'b1;
    logic        op_ready, busy, result_valid, result_jump_flag;
    logic [31:0] result_value;
    logic [4:0]  result_addr;
    logic [2:0]  result_reg_status;

    gecko_muldiv_sequencer dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_is_div(op_is_div), .op_math_type(op_math_type), .op_a(op_a), .op_b(op_b),
        .op_reg_addr(op_reg_addr), .op_reg_status(op_reg_status), .op_jump_flag(op_jump_flag),
        .flush(flush), .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .result_value(result_value), .result_addr(result_addr),
        .result_reg_status(result_reg_status), .result_jump_flag(result_jump_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int errs = 0;
    int nchk = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: RV32M semantics from plain wide arithmetic.
    function automatic logic [31:0] ref_result(input logic isdiv, input logic [1:0] t,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea, eb, p;
        int sa, sb;
        if (!isdiv) begin
            ea = (t == 2'd1 || t == 2'd3) ? {{32{a[31]}}, a} : {32'd0, a};
            eb = (t == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
            p  = ea * eb;
            return (t == 2'd0) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return t[1] ? a : 32'hFFFF_FFFF;
        sa = a;
        sb = b;
        case (t)
            2'd0: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            2'd1: return a / b;
            2'd2: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    // Model: at most one outstanding op; it becomes visible at a known cycle.
    typedef struct {
        logic [31:0] val;
        logic [4:0]  addr;
        logic [2:0]  st;
        logic        jf;
        int          due;
    } exp_t;
    exp_t pend;
    bit   have = 0;
    bit   ev, er;

    always @(negedge clk) begin
        if (rst) begin
            have = 0;
            chk("rst_valid", 32'(result_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_value", result_value, 32'd0);
            chk("rst_addr", 32'(result_addr), 32'd0);
            chk("rst_status", 32'(result_reg_status), 32'd0);
            chk("rst_jump", 32'(result_jump_flag), 32'd0);
        end else begin
            ev = have && (cyc >= pend.due);
            er = !flush && (!have || (ev && result_ready));
            chk("op_ready", 32'(op_ready), 32'(er));
            chk("result_valid", 32'(result_valid), 32'(ev));
            chk("busy", 32'(busy), 32'(have));
            if (ev && result_valid) begin
                chk("value", result_value, pend.val);
                chk("addr", 32'(result_addr), 32'(pend.addr));
                chk("status", 32'(result_reg_status), 32'(pend.st));
                chk("jump", 32'(result_jump_flag), 32'(pend.jf));
            end
            if (flush) have = 0;
            else begin
                if (ev && result_ready) have = 0;
                if (op_valid && er) begin
                    pend.val  = ref_result(op_is_div, op_math_type, op_a, op_b);
                    pend.addr = op_reg_addr;
                    pend.st   = op_reg_status;
                    pend.jf   = op_jump_flag;
                    pend.due  = cyc + ((op_is_div && op_b == 32'd0) ? 2 : 34);
                    have = 1;
                end
            end
        end
    end

    task automatic drive_op(input logic isdiv, input logic [1:0] t,
                            input logic [31:0] a, input logic [31:0] b);
        op_valid      = 1'b1;
        op_is_div     = isdiv;
        op_math_type  = t;
        op_a          = a;
        op_b          = b;
        op_reg_addr   = 5'($urandom);
        op_reg_status = 3'($urandom);
        op_jump_flag  = 1'($urandom);
    endtask

    // Wait (bounded) for result_valid; returns cycles since the accept cycle.
    task automatic wait_valid(input int acc, output int lat);
        int n = 0;
        while (!result_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        lat = result_valid ? (cyc - acc) : -1;
    endtask

    task automatic do_op(input string nm, input logic isdiv, input logic [1:0] t,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
        int acc, lat;
        logic [4:0] ad;
        @(posedge clk); #1;
        drive_op(isdiv, t, a, b);
        ad  = op_reg_addr;
        acc = cyc;
        @(posedge clk); #1;
        op_valid = 1'b0;
        wait_valid(acc, lat);
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_value"}, result_value, exp);
        chk({nm, "_addr"}, 32'(result_addr), 32'(ad));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, lat, hi_cnt;
        logic [31:0] held;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("reset_op_ready", 32'(op_ready), 32'd1);

        // pin the reference model to hand-computed values
        chk("ref_mul", ref_result(1'b0, 2'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("ref_mulh", ref_result(1'b0, 2'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        chk("ref_mulhsu", ref_result(1'b0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("ref_div", ref_result(1'b1, 2'd0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("ref_rem", ref_result(1'b1, 2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        result_ready = 1'b1;
        do_op("mul",    1'b0, 2'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        do_op("mulh",   1'b0, 2'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        do_op("mulhu",  1'b0, 2'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        do_op("mulhsu", 1'b0, 2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        do_op("div",    1'b1, 2'd0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        do_op("rem",    1'b1, 2'd2, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        do_op("div_ovf",1'b1, 2'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34);
        do_op("rem_ovf",1'b1, 2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34);
        do_op("divu_z", 1'b1, 2'd1, 32'd5,          32'd0,         32'hFFFF_FFFF, 2);
        do_op("remu_z", 1'b1, 2'd3, 32'd5,          32'd0,         32'd5,         2);
        do_op("rem_zn", 1'b1, 2'd2, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 2);

        // backpressure, then consume and accept in the same cycle
        result_ready = 1'b0;
        @(posedge clk); #1;
        drive_op(1'b0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        acc = cyc;
        @(posedge clk); #1;
        op_valid = 1'b0;
        wait_valid(acc, lat);
        chk("bp_latency", 32'(lat), 32'd34);
        held = result_value;
        chk("bp_value", held, 32'hFFFF_FFFE);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_stable", result_value, 32'hFFFF_FFFE);
            chk("bp_op_ready", 32'(op_ready), 32'd0);
        end
        drive_op(1'b1, 2'd0, 32'hFFFF_FFF9, 32'd2);
        result_ready = 1'b1;
        acc = cyc;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("b2b_valid_drop", 32'(result_valid), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_valid(acc, lat);
        chk("b2b_latency", 32'(lat), 32'd34);
        chk("b2b_value", result_value, 32'hFFFF_FFFD);
        @(posedge clk); #1;

        // flush at count 10
        drive_op(1'b0, 2'd0, 32'd123, 32'd456);
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        hi_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid) hi_cnt++;
        end
        chk("flush_no_result", 32'(hi_cnt), 32'd0);

        // asynchronous reset mid-iteration
        drive_op(1'b1, 2'd0, 32'd1000, 32'd7);
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(result_valid), 32'd0);
        chk("arst_value", result_value, 32'd0);
        chk("arst_op_ready", 32'(op_ready), 32'd1);
        @(negedge clk); #1 rst = 1'b0;
        do_op("post_rst", 1'b1, 2'd0, 32'd1000, 32'd7, 32'd142, 34);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            drive_op(1'($urandom_range(0, 1)), 2'($urandom), rnd_opnd(), rnd_opnd());
            op_valid     = ($urandom_range(0, 3) != 0);
            result_ready = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        result_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
